// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and timing defaults for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // start + 8 data + parity + stop; the host shifts all but the start bit
  localparam int PS2_FRAME_BITS  = 11;
  localparam int DEF_CLK_INHIBIT = 5000;
  localparam int DEF_TIMEOUT     = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF synchronizer with a registered falling-edge strobe
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);

  logic s1;
  logic q_prev;

  // PS/2 lines idle high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      q      <= 1'b1;
      q_prev <= 1'b1;
      fall   <= 1'b0;
    end else begin
      s1     <= d;
      q      <= s1;
      q_prev <= q;
      fall   <= q_prev & ~q;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (inhibit, request, shift, ack)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_INHIBIT = DEF_CLK_INHIBIT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX   = (CLK_INHIBIT > TIMEOUT) ? CLK_INHIBIT : TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam int LAST_IDX  = PS2_FRAME_BITS - 2;

  ps2_state_t                  state;
  logic [CNT_W-1:0]            cnt;
  logic [3:0]                  idx;
  logic [PS2_FRAME_BITS-2:0]   frame;
  logic                        clk_s;
  logic                        clk_fall;
  logic                        dat_s;
  logic                        dat_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (ps2_clk_in),
    .q     (clk_s),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_dat (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (ps2_dat_in),
    .q     (dat_s),
    .fall  (dat_fall_unused)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (start) begin
            frame      <= {1'b1, odd_parity(tx_data), tx_data};
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          cnt <= cnt + CNT_W'(1);
          // start bit goes low in the final inhibit cycle, before clock is released
          if (cnt == CNT_W'(CLK_INHIBIT - 2)) ps2_dat_oe <= 1'b1;
          if (cnt == CNT_W'(CLK_INHIBIT - 1)) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= REQ;
          end
        end

        default: begin
          if (clk_fall) begin
            cnt <= '0;
            case (state)
              REQ: begin
                ps2_dat_oe <= ~frame[0];
                idx        <= '0;
                state      <= SHIFT;
              end
              SHIFT: begin
                if (idx == 4'(LAST_IDX)) begin
                  ps2_dat_oe <= 1'b0;
                  state      <= ACK;
                end else begin
                  idx        <= idx + 4'd1;
                  ps2_dat_oe <= ~frame[idx + 4'd1];
                end
              end
              ACK: begin
                if (dat_s) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end else begin
                  state <= WAIT_IDLE;
                end
              end
              default: ;
            endcase
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            err        <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == WAIT_IDLE && clk_s && dat_s) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - table-driven bench with PS/2 device model and scoreboards
module tb_ps2_host_tx;

  localparam int CLK_INHIBIT = 5000;
  localparam int TIMEOUT     = 3000;
  localparam int HALF        = 20;

  logic       CLOCK_50;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic       dev_clk_low;
  logic       dev_dat_low;

  int passed = 0;
  int total  = 0;

  logic       bit_q[$];
  logic [1:0] out_q[$];

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         mode;
    logic [1:0] exp_out;
  } vec_t;

  ps2_host_tx #(
    .CLK_INHIBIT (CLK_INHIBIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .start      (start),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // done = 2'b01, err = 2'b10; every pulse cycle must match the next expected outcome
  always @(negedge CLOCK_50) begin
    if (done || err) begin
      if (out_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, err, done}, 32'd0);
      end else begin
        check("outcome", {30'd0, err, done}, {30'd0, out_q.pop_front()});
      end
      check("busy_drops_with_pulse", busy, 0);
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2) == 0;
  endfunction

  // mode: 0 normal, 1 second start during SHIFT, 2 reset during bit 4, 3 device never clocks
  task automatic send(input logic [7:0] d, input logic ack, input int mode, input logic [1:0] exp_out);
    int hi;
    int dat_at;
    int n;
    logic exp;
    if (mode != 3) begin
      for (int i = 0; i < 8; i++) bit_q.push_back(~d[i]);
      bit_q.push_back(~odd_par(d));
      bit_q.push_back(1'b0);
      bit_q.push_back(1'b0);
    end
    out_q.push_back(exp_out);
    start   = 1'b1;
    tx_data = d;
    @(negedge CLOCK_50);
    start   = 1'b0;
    tx_data = 8'($urandom);
    n = 0;
    while (!ps2_clk_oe && n < 20) begin @(negedge CLOCK_50); n++; end
    check("clk_oe_rises", ps2_clk_oe, 1);
    check("busy_after_start", busy, 1);
    hi = 0;
    dat_at = -1;
    while (ps2_clk_oe && hi < 2 * CLK_INHIBIT) begin
      if (ps2_dat_oe && dat_at < 0) dat_at = hi;
      hi++;
      @(negedge CLOCK_50);
    end
    check("inhibit_len", hi, CLK_INHIBIT);
    check("dat_oe_one_before_clk_release", dat_at, CLK_INHIBIT - 1);
    check("dat_oe_in_req", ps2_dat_oe, 1);
    if (mode == 3) begin
      n = 0;
      while (!err && n < TIMEOUT + 100) begin @(negedge CLOCK_50); n++; end
      check("timeout_latency", n, TIMEOUT);
      check("timeout_clk_released", ps2_clk_oe, 0);
      check("timeout_dat_released", ps2_dat_oe, 0);
    end else begin
      repeat (10) @(negedge CLOCK_50);
      for (int e = 1; e <= 12; e++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        if (e <= 11) begin
          exp = bit_q.pop_front();
          check($sformatf("dat_oe_edge_%0d", e), ps2_dat_oe, exp);
        end
        if (e == 11 && ack) dev_dat_low = 1'b1;
        if (e == 12) dev_dat_low = 1'b0;
        if (mode == 1 && e == 3) begin
          start   = 1'b1;
          tx_data = 8'hFF;
          @(negedge CLOCK_50);
          start   = 1'b0;
          check("busy_during_ignored_start", busy, 1);
        end
        if (mode == 2 && e == 5) begin
          bit_q.delete();
          out_q.delete();
          reset_n = 1'b0;
          #1;
          check("reset_clk_oe_same_cycle", ps2_clk_oe, 0);
          check("reset_dat_oe_same_cycle", ps2_dat_oe, 0);
          check("reset_busy", busy, 0);
          return;
        end
      end
    end
    n = 0;
    while (busy && n < 200) begin @(negedge CLOCK_50); n++; end
    repeat (5) @(negedge CLOCK_50);
    check("busy_after_frame", busy, 0);
    check("clk_oe_after_frame", ps2_clk_oe, 0);
    check("dat_oe_after_frame", ps2_dat_oe, 0);
    check("outcome_seen", out_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{data: 8'hED, ack: 1'b1, mode: 0, exp_out: 2'b01};
    vecs[1] = '{data: 8'h00, ack: 1'b1, mode: 0, exp_out: 2'b01};
    vecs[2] = '{data: 8'hA5, ack: 1'b0, mode: 0, exp_out: 2'b10};
    vecs[3] = '{data: 8'h5A, ack: 1'b1, mode: 1, exp_out: 2'b01};
    vecs[4] = '{data: 8'hC3, ack: 1'b1, mode: 3, exp_out: 2'b10};

    reset_n     = 1'b0;
    start       = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].data, vecs[v].ack, vecs[v].mode, vecs[v].exp_out);
      repeat (20) @(negedge CLOCK_50);
    end

    send(8'h33, 1'b1, 2, 2'b01);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (100) @(negedge CLOCK_50);
    check("idle_after_reset_release", busy, 0);
    check("clk_oe_after_reset_release", ps2_clk_oe, 0);
    send(8'hF4, 1'b1, 0, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
